// File: rtl/qqspi_read_cache.sv
// rtl/qqspi_read_cache.sv - direct-mapped write-through read cache in front of the quad-SPI controller
//
// Purpose:
//   Direct-mapped cache with one 32-bit word per line. Writes go through to
//   memory and are never allocated. Repeated reads are served locally, so they
//   never reach the serial link.
//
// Ports:
//   clk, reset                 system clock; synchronous active-high reset
//   flush                      one-cycle pulse; invalidates every line at the next idle cycle
//   cpu_valid/addr/wdata/wstrb CPU request (wstrb == 0 means read)
//   cpu_rdata, cpu_ready       CPU response; cpu_ready is a one-cycle completion pulse
//   mem_valid/addr/wdata/wstrb request to the controller; held stable until mem_ready
//   mem_rdata, mem_ready       controller response; mem_ready stays high until mem_valid drops
module qqspi_read_cache #(
  parameter int LINES      = 64,
  parameter int ADDR_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  cpu_valid,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);

  localparam int IDX = $clog2(LINES);
  localparam int TAG = ADDR_WIDTH - IDX;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MEM_REQ, S_DRAIN} state_t;

  state_t                r_state;
  logic [LINES-1:0]      r_valid;
  logic                  r_flush_pend;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;

  // Tag/data storage carries no reset so it can map onto RAM.
  logic [TAG-1:0]        r_tag_mem  [LINES];
  logic [31:0]           r_data_mem [LINES];
  logic [TAG-1:0]        r_line_tag;
  logic [31:0]           r_line_data;
  logic                  r_line_valid;

  logic [IDX-1:0]        w_idx;
  logic [IDX-1:0]        w_r_idx;
  logic [TAG-1:0]        w_r_tag;
  logic                  w_accept;
  logic                  w_is_write;
  logic                  w_hit;
  logic [31:0]           w_merged;
  logic                  w_arr_we;
  logic [31:0]           w_arr_wdata;

  assign w_idx      = cpu_addr[IDX-1:0];
  assign w_r_idx    = r_addr[IDX-1:0];
  assign w_r_tag    = r_addr[ADDR_WIDTH-1:IDX];
  // cpu_ready is high in the idle cycle right after a hit; the request still
  // held on cpu_valid then is the one just completed, not a new one.
  assign w_accept   = (r_state == S_IDLE) && !r_flush_pend && cpu_valid && !cpu_ready;
  assign w_is_write = |r_wstrb;
  assign w_hit      = r_line_valid && (r_line_tag == w_r_tag);

  // Byte merge for a write hit: only strobed lanes take the new data.
  always_comb begin
    w_merged = r_line_data;
    for (int b = 0; b < 4; b++) begin
      if (r_wstrb[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
    end
  end

  // Single array write port: write-hit merge in LOOKUP, read fill in MEM_REQ.
  assign w_arr_we    = !reset &&
                       (((r_state == S_LOOKUP) && w_is_write && w_hit) ||
                        ((r_state == S_MEM_REQ) && mem_ready && !w_is_write));
  assign w_arr_wdata = (r_state == S_LOOKUP) ? w_merged : mem_rdata;

  always_ff @(posedge clk) begin
    if (w_arr_we) begin
      r_tag_mem[w_r_idx]  <= w_r_tag;
      r_data_mem[w_r_idx] <= w_arr_wdata;
    end
    if (w_accept) begin
      r_line_tag  <= r_tag_mem[w_idx];
      r_line_data <= r_data_mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_line_valid <= 1'b0;
      cpu_ready    <= 1'b0;
      cpu_rdata    <= '0;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
    end else begin
      cpu_ready <= 1'b0;
      if (flush) r_flush_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_flush_pend) begin
            r_valid      <= '0;
            // A flush pulse landing on the apply cycle re-arms the flag.
            r_flush_pend <= flush;
          end else if (cpu_valid && !cpu_ready) begin
            r_addr       <= cpu_addr;
            r_wdata      <= cpu_wdata;
            r_wstrb      <= cpu_wstrb;
            r_line_valid <= r_valid[w_idx];
            r_state      <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (!w_is_write && w_hit) begin
            cpu_rdata <= r_line_data;
            cpu_ready <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            // Read miss or any write (write-through).
            mem_valid <= 1'b1;
            mem_addr  <= r_addr;
            mem_wstrb <= r_wstrb;
            if (w_is_write) mem_wdata <= r_wdata;
            r_state   <= S_MEM_REQ;
          end
        end

        S_MEM_REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            cpu_ready <= 1'b1;
            if (w_is_write) begin
              cpu_rdata <= '0;
            end else begin
              cpu_rdata        <= mem_rdata;
              r_valid[w_r_idx] <= 1'b1;
            end
            r_state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          // Controller keeps mem_ready high until it sees mem_valid low.
          if (!mem_ready) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qqspi_read_cache.sv
// tb/tb_qqspi_read_cache.sv - directed table-driven bench for qqspi_read_cache
module tb_qqspi_read_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        cpu_valid;
  logic [22:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_valid;
  logic [22:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qqspi_read_cache #(.LINES(64), .ADDR_WIDTH(23)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] mdata;     // controller read data
    int          lat;       // controller latency in cycles
    int          flush_at;  // -1 none, 0 one cycle before valid, n at cycle n
    logic [31:0] exp_rdata;
    int          exp_nreq;
  } vec_t;

  // One CPU request with an inline controller model.
  task automatic do_req(input vec_t v, output logic [31:0] rdata, output int nreq,
                        output int cycles, output logic [22:0] s_addr,
                        output logic [31:0] s_wdata, output logic [3:0] s_wstrb,
                        output bit timeout);
    int cnt = 0, lat = 0;
    bit got = 0, done = 0, prev_mv = 0;
    nreq = 0; cycles = 0; rdata = '0; timeout = 0;
    s_addr = '0; s_wdata = '0; s_wstrb = '0;
    if (v.flush_at == 0) begin
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    cpu_valid = 1'b1; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_wstrb = v.wstrb;
    while (!done && cnt < 300) begin
      @(negedge clk);
      cnt++;
      flush = (v.flush_at > 0 && cnt == v.flush_at);
      if (mem_valid && !prev_mv) begin
        nreq++; s_addr = mem_addr; s_wdata = mem_wdata; s_wstrb = mem_wstrb;
      end
      prev_mv = mem_valid;
      if (cpu_ready && !got) begin
        got = 1; rdata = cpu_rdata; cycles = cnt - 1; cpu_valid = 1'b0;
      end
      if (mem_valid && !mem_ready) begin
        lat++;
        if (lat >= v.lat) begin mem_ready = 1'b1; mem_rdata = v.mdata; end
      end else if (!mem_valid && mem_ready) begin
        mem_ready = 1'b0;
      end
      if (got && !mem_ready) done = 1;
    end
    flush = 1'b0;
    if (!done) begin timeout = 1; cpu_valid = 1'b0; mem_ready = 1'b0; end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] rd, wd; logic [22:0] ad; logic [3:0] ws; int nr, cy; bit to;
    do_req(v, rd, nr, cy, ad, wd, ws, to);
    check({v.name, " timeout"}, 32'(to), 32'd0);
    check({v.name, " rdata"}, rd, v.exp_rdata);
    check({v.name, " mem_reqs"}, 32'(nr), 32'(v.exp_nreq));
    if (v.exp_nreq == 0) check({v.name, " hit_latency"}, 32'(cy), 32'd2);
    if (v.exp_nreq > 0) begin
      check({v.name, " mem_addr"}, 32'(ad), 32'(v.addr));
      check({v.name, " mem_wstrb"}, 32'(ws), 32'(v.wstrb));
      if (v.wstrb != 4'b0) check({v.name, " mem_wdata"}, wd, v.wdata);
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] rd_hold; bit got_r; int viol, mv_seen, cnt, lat;
    vec_t v;

    reset = 1'b1; flush = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_wstrb = '0; mem_rdata = '0; mem_ready = 1'b0;

    //        name        addr      wdata         wstrb    mdata         lat flush exp_rdata   nreq
    vecs.push_back('{"cold_rd",   23'h105, 32'h0,        4'b0000, 32'hDEADBEEF, 40, -1, 32'hDEADBEEF, 1});
    vecs.push_back('{"hit_rd",    23'h105, 32'h0,        4'b0000, 32'h0,         1, -1, 32'hDEADBEEF, 0});
    vecs.push_back('{"wr_hit",    23'h105, 32'h0000AA00, 4'b0010, 32'h0,         2, -1, 32'h0,        1});
    vecs.push_back('{"rd_merged", 23'h105, 32'h0,        4'b0000, 32'h0,         1, -1, 32'hDEADAAEF, 0});
    vecs.push_back('{"wr_hit2",   23'h105, 32'h55BBCC66, 4'b1001, 32'h0,         3, -1, 32'h0,        1});
    vecs.push_back('{"rd_merged2",23'h105, 32'h0,        4'b0000, 32'h0,         1, -1, 32'h55ADAA66, 0});
    vecs.push_back('{"wr_miss",   23'h200, 32'h12345678, 4'b1111, 32'h0,         3, -1, 32'h0,        1});
    vecs.push_back('{"rd_noalloc",23'h200, 32'h0,        4'b0000, 32'hCAFEF00D,  4, -1, 32'hCAFEF00D, 1});
    vecs.push_back('{"alias_a",   23'h005, 32'h0,        4'b0000, 32'h11111111,  2, -1, 32'h11111111, 1});
    vecs.push_back('{"alias_b",   23'h045, 32'h0,        4'b0000, 32'h22222222,  2, -1, 32'h22222222, 1});
    vecs.push_back('{"alias_a2",  23'h005, 32'h0,        4'b0000, 32'h11111111,  2, -1, 32'h11111111, 1});
    vecs.push_back('{"alias_a3",  23'h005, 32'h0,        4'b0000, 32'h0,         1, -1, 32'h11111111, 0});
    vecs.push_back('{"flush_mid", 23'h010, 32'h0,        4'b0000, 32'h0F0F0F0F, 10,  5, 32'h0F0F0F0F, 1});
    vecs.push_back('{"after_fl",  23'h010, 32'h0,        4'b0000, 32'h0F0F0F0F,  2, -1, 32'h0F0F0F0F, 1});
    vecs.push_back('{"refilled",  23'h010, 32'h0,        4'b0000, 32'h0,         1, -1, 32'h0F0F0F0F, 0});
    vecs.push_back('{"fl_lost",   23'h105, 32'h0,        4'b0000, 32'h77777777,  2, -1, 32'h77777777, 1});
    vecs.push_back('{"fl_wins",   23'h010, 32'h0,        4'b0000, 32'hABABABAB,  2,  0, 32'hABABABAB, 1});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst cpu_rdata", cpu_rdata, 32'd0);
    check("rst mem_valid", 32'(mem_valid), 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Controller holds mem_ready after completion while the CPU re-requests a cached line.
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_addr = 23'h300; cpu_wstrb = 4'b0;
    got_r = 0; cnt = 0; lat = 0;
    while (!got_r && cnt < 100) begin
      @(negedge clk); cnt++;
      if (cpu_ready) begin got_r = 1; rd_hold = cpu_rdata; cpu_valid = 1'b0; end
      else if (mem_valid && !mem_ready) begin
        lat++;
        if (lat >= 2) begin mem_ready = 1'b1; mem_rdata = 32'h44444444; end
      end
    end
    check("drain first ready", 32'(got_r), 32'd1);
    check("drain first rdata", rd_hold, 32'h44444444);
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_addr = 23'h010;
    viol = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_valid || cpu_ready) viol++;
    end
    mem_ready = 1'b0;
    check("drain blocked", 32'(viol), 32'd0);
    got_r = 0; mv_seen = 0; cnt = 0;
    while (!got_r && cnt < 20) begin
      @(negedge clk); cnt++;
      if (mem_valid) mv_seen++;
      if (cpu_ready) begin got_r = 1; rd_hold = cpu_rdata; cpu_valid = 1'b0; end
    end
    check("drain then hit ready", 32'(got_r), 32'd1);
    check("drain then hit rdata", rd_hold, 32'hABABABAB);
    check("drain then hit no mem", 32'(mv_seen), 32'd0);
    cpu_valid = 1'b0;

    // Reset while a miss is outstanding in MEM_REQ.
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_addr = 23'h020; cpu_wstrb = 4'b0;
    repeat (5) @(negedge clk);
    check("pre-reset mem_valid", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset mem_valid", 32'(mem_valid), 32'd0);
    check("mid reset cpu_ready", 32'(cpu_ready), 32'd0);
    check("mid reset mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0; cpu_valid = 1'b0;
    v = '{"post_rst", 23'h010, 32'h0, 4'b0000, 32'h99999999, 2, -1, 32'h99999999, 1};
    run_vec(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
